pcileech_tlps128_rx_fifo: RTL and testbench

Receive-side TLP buffer between the 128-bit PCIe RX stream and the FT601/FIFO transmit path. It accepts beats from an `IfAXIS128` sink and optionally discards whole TLPs under the all-TLP filter. It stores accepted beats in a first-word-fall-through buffer and presents them as four DW lanes on the `IfPCIeFifoTlp` `mp_pcie` receive side (`rx_data[4]`, `rx_first[4]`, `rx_last[4]`, `rx_valid[4]`, `rx_rd_en`).

---
 rtl/pcileech_tlps128_pkg.sv | 31 +++
 rtl/pcileech_tlps128_rx_fifo_mem.sv | 27 ++
 rtl/pcileech_tlps128_rx_fifo.sv | 163 ++++++++++++++++
 tb/tb_pcileech_tlps128_rx_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_tlps128_pkg.sv
// Shared types for the 128-bit TLP receive buffer: the stored entry layout,
// the filter FSM states and the DW-lane last-marker helper.
package pcileech_tlps128_pkg;

  // One buffered beat: 128 data bits plus per-DW valid/first/last markers.
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   valid;
    logic [3:0]   first;
    logic [3:0]   last;
  } tlps128_entry_t;

  // Filter FSM: waiting for a TLP start, forwarding a TLP, or discarding one.
  typedef enum logic [1:0] {
    RXF_IDLE = 2'd0,
    RXF_PASS = 2'd1,
    RXF_DROP = 2'd2
  } tlps128_rxf_state_t;

  // Marks the highest kept DW of a beat as the TLP's last DW when tlast is set.
  function automatic logic [3:0] tlps128_last_mask(input logic [3:0] keepdw,
                                                   input logic       tlast);
    logic [3:0] mask;
    mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      mask[i] = tlast && keepdw[i] && ((keepdw >> (i + 1)) == 4'b0000);
    end
    return mask;
  endfunction

endpackage

// File: rtl/pcileech_tlps128_rx_fifo_mem.sv
// Simple dual-port entry storage with a registered read port. The read
// register doubles as the first-word-fall-through output stage.
module pcileech_tlps128_rx_fifo_mem
  import pcileech_tlps128_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  tlps128_entry_t wr_data,
  input  logic [AW-1:0]  rd_addr,
  output tlps128_entry_t rd_data
);

  tlps128_entry_t mem [DEPTH];

  // Write the incoming entry and register the entry at the look-ahead read address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pcileech_tlps128_rx_fifo.sv
// Receive-side TLP buffer: filters whole TLPs, stores accepted 128-bit beats
// in a first-word-fall-through buffer and presents them as four DW lanes.
module pcileech_tlps128_rx_fifo
  import pcileech_tlps128_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] tlps_in_tdata,
  input  logic [3:0]   tlps_in_tkeepdw,
  input  logic         tlps_in_tvalid,
  input  logic         tlps_in_tlast,
  input  logic [8:0]   tlps_in_tuser,
  output logic         tlps_in_tready,
  input  logic         alltlp_filter,
  output logic [31:0]  rx_data  [4],
  output logic         rx_first [4],
  output logic         rx_last  [4],
  output logic         rx_valid [4],
  input  logic         rx_rd_en,
  output logic [15:0]  cnt_tlp,
  output logic [15:0]  cnt_drop,
  output logic [15:0]  cnt_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tlps128_rxf_state_t state, state_nxt;
  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_addr;
  logic               head_valid;
  tlps128_entry_t     wr_entry, head_entry;
  logic               beat_fire, beat_first, beat_empty;
  logic               wr_req, push, pop;
  logic               inc_tlp, inc_drop, inc_orphan_idle, orphan_hit;
  logic               unused_tuser;

  assign unused_tuser = ^tlps_in_tuser[8:1];

  // In DROP beats are discarded, so only buffer space can stall the stream.
  assign tlps_in_tready = rst_n && ((state == RXF_DROP) || (count < CW'(DEPTH)));
  assign beat_fire      = tlps_in_tvalid && tlps_in_tready;
  assign beat_first     = tlps_in_tuser[0];
  assign beat_empty     = (tlps_in_tkeepdw == 4'b0000);

  // A beat with no kept DWs is swallowed as an orphan instead of being stored.
  assign push       = wr_req && !beat_empty;
  assign orphan_hit = inc_orphan_idle || (wr_req && beat_empty);

  // Popping is gated on a visible head so a just-written, not yet presented
  // entry can never be consumed unseen; head_valid implies count > 0.
  assign pop     = rx_rd_en && head_valid;
  assign rd_addr = rd_ptr + AW'(pop);

  assign wr_entry.data  = tlps_in_tdata;
  assign wr_entry.valid = tlps_in_tkeepdw;
  assign wr_entry.first = {3'b000, beat_first};
  assign wr_entry.last  = tlps128_last_mask(tlps_in_tkeepdw, tlps_in_tlast);

  pcileech_tlps128_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_addr),
    .rd_data (head_entry)
  );

  // Filter FSM next state and per-beat actions for each accepted beat.
  always_comb begin
    state_nxt       = state;
    wr_req          = 1'b0;
    inc_tlp         = 1'b0;
    inc_drop        = 1'b0;
    inc_orphan_idle = 1'b0;
    if (beat_fire) begin
      case (state)
        RXF_IDLE: begin
          if (beat_first) begin
            if (alltlp_filter) begin
              if (tlps_in_tlast) inc_drop  = 1'b1;
              else               state_nxt = RXF_DROP;
            end else begin
              wr_req = 1'b1;
              if (tlps_in_tlast) inc_tlp   = 1'b1;
              else               state_nxt = RXF_PASS;
            end
          end else begin
            inc_orphan_idle = 1'b1;
          end
        end
        RXF_PASS: begin
          wr_req = 1'b1;
          if (tlps_in_tlast) begin
            inc_tlp   = 1'b1;
            state_nxt = RXF_IDLE;
          end
        end
        RXF_DROP: begin
          if (tlps_in_tlast) begin
            inc_drop  = 1'b1;
            state_nxt = RXF_IDLE;
          end
        end
        default: state_nxt = RXF_IDLE;
      endcase
    end
  end

  // Filter FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RXF_IDLE;
    else        state <= state_nxt;
  end

  // Buffer pointers, occupancy and head-valid flag; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      head_valid <= (count - CW'(pop)) != '0;
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_tlp    <= 16'd0;
      cnt_drop   <= 16'd0;
      cnt_orphan <= 16'd0;
    end else begin
      if (inc_tlp)    cnt_tlp    <= cnt_tlp + 16'd1;
      if (inc_drop)   cnt_drop   <= cnt_drop + 16'd1;
      if (orphan_hit) cnt_orphan <= cnt_orphan + 16'd1;
    end
  end

  // Split the head entry into DW lanes; markers are held low while in reset.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rx_data[i]  = head_entry.data[32*i +: 32];
      rx_valid[i] = rst_n && head_valid && head_entry.valid[i];
      rx_first[i] = rst_n && head_valid && head_entry.first[i];
      rx_last[i]  = rst_n && head_valid && head_entry.last[i];
    end
  end

endmodule

// File: tb/tb_pcileech_tlps128_rx_fifo.sv
// Directed bench for the TLP receive buffer: a table of single-beat cases
// followed by hand-written multi-cycle sequences.
module tb_pcileech_tlps128_rx_fifo;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] tdata;
  logic [3:0]   tkeepdw;
  logic         tvalid;
  logic         tlast;
  logic [8:0]   tuser;
  logic         tready;
  logic         filter;
  logic [31:0]  rx_data  [4];
  logic         rx_first [4];
  logic         rx_last  [4];
  logic         rx_valid [4];
  logic         rx_rd_en;
  logic [15:0]  cnt_tlp, cnt_drop, cnt_orphan;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcileech_tlps128_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tlps_in_tdata   (tdata),
    .tlps_in_tkeepdw (tkeepdw),
    .tlps_in_tvalid  (tvalid),
    .tlps_in_tlast   (tlast),
    .tlps_in_tuser   (tuser),
    .tlps_in_tready  (tready),
    .alltlp_filter   (filter),
    .rx_data         (rx_data),
    .rx_first        (rx_first),
    .rx_last         (rx_last),
    .rx_valid        (rx_valid),
    .rx_rd_en        (rx_rd_en),
    .cnt_tlp         (cnt_tlp),
    .cnt_drop        (cnt_drop),
    .cnt_orphan      (cnt_orphan)
  );

  typedef struct {
    logic [3:0]  keep;
    logic        first;
    logic        last;
    logic        filt;
    logic [31:0] base;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_first;
    logic [3:0]  exp_last;
    logic [31:0] exp_tlp;
    logic [31:0] exp_drop;
    logic [31:0] exp_orphan;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [3:0] validMask();
    return {rx_valid[3], rx_valid[2], rx_valid[1], rx_valid[0]};
  endfunction

  function automatic logic [3:0] firstMask();
    return {rx_first[3], rx_first[2], rx_first[1], rx_first[0]};
  endfunction

  function automatic logic [3:0] lastMask();
    return {rx_last[3], rx_last[2], rx_last[1], rx_last[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkHead(input string name, input logic [3:0] ev, input logic [3:0] ef,
                           input logic [3:0] el, input logic [31:0] base);
    checkOutput({name, ".valid"}, 32'(validMask()), 32'(ev));
    checkOutput({name, ".first"}, 32'(firstMask()), 32'(ef));
    checkOutput({name, ".last"},  32'(lastMask()),  32'(el));
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) checkOutput($sformatf("%s.data%0d", name, i), rx_data[i], base + 32'(i));
    end
  endtask

  task automatic checkCounters(input string name, input logic [31:0] et,
                               input logic [31:0] ed, input logic [31:0] eo);
    checkOutput({name, ".cnt_tlp"},    32'(cnt_tlp),    et);
    checkOutput({name, ".cnt_drop"},   32'(cnt_drop),   ed);
    checkOutput({name, ".cnt_orphan"}, 32'(cnt_orphan), eo);
  endtask

  task automatic driveBeat(input logic [3:0] keep, input logic first, input logic last,
                           input logic filt, input logic [31:0] base);
    tdata   = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    tkeepdw = keep;
    tuser   = {8'h00, first};
    tlast   = last;
    filter  = filt;
    tvalid  = 1'b1;
  endtask

  task automatic idleIn();
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tuser   = 9'h000;
    filter  = 1'b0;
    tkeepdw = 4'h0;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [3:0] keep, input logic first, input logic last,
                               input logic filt, input logic [31:0] base);
    int waitCycles;
    waitCycles = 0;
    driveBeat(keep, first, last, filt, base);
    while (!tready && waitCycles < 64) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!tready) begin
      total++;
      bad++;
      $display("[TB] FAIL tready_wait: got tready=0, expected 1 within %0d cycles", waitCycles);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic popOne();
    rx_rd_en = 1'b1;
    @(posedge clk); #1;
    rx_rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    rx_rd_en = 1'b0;
    tdata    = '0;
    idleIn();

    vecs[0] = '{4'h7, 1'b1, 1'b1, 1'b0, 32'h0100, 4'h7, 4'h1, 4'h4, 32'd1, 32'd0, 32'd0};
    vecs[1] = '{4'hF, 1'b1, 1'b1, 1'b0, 32'h0110, 4'hF, 4'h1, 4'h8, 32'd2, 32'd0, 32'd0};
    vecs[2] = '{4'h1, 1'b1, 1'b1, 1'b0, 32'h0120, 4'h1, 4'h1, 4'h1, 32'd3, 32'd0, 32'd0};
    vecs[3] = '{4'h3, 1'b1, 1'b1, 1'b1, 32'h0130, 4'h0, 4'h0, 4'h0, 32'd3, 32'd1, 32'd0};
    vecs[4] = '{4'hF, 1'b0, 1'b0, 1'b0, 32'h0140, 4'h0, 4'h0, 4'h0, 32'd3, 32'd1, 32'd1};
    vecs[5] = '{4'h3, 1'b1, 1'b1, 1'b0, 32'h0150, 4'h3, 4'h1, 4'h2, 32'd4, 32'd1, 32'd1};
    vecs[6] = '{4'hF, 1'b0, 1'b1, 1'b0, 32'h0160, 4'h0, 4'h0, 4'h0, 32'd4, 32'd1, 32'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.valid", 32'(validMask()), 32'h0);
    checkOutput("reset.tready", 32'(tready), 32'h0);
    checkCounters("reset", 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle.tready", 32'(tready), 32'h1);

    // Read request on an empty buffer must be ignored
    popOne();
    checkOutput("emptyPop.valid", 32'(validMask()), 32'h0);

    // Table of single-beat cases
    for (int v = 0; v < 7; v++) begin
      checkOutput($sformatf("vec%0d.tready", v), 32'(tready), 32'h1);
      applyStimulus(vecs[v].keep, vecs[v].first, vecs[v].last, vecs[v].filt, vecs[v].base);
      idleIn();
      @(posedge clk); #1;
      checkHead($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_first,
                vecs[v].exp_last, vecs[v].base);
      checkCounters($sformatf("vec%0d", v), vecs[v].exp_tlp, vecs[v].exp_drop, vecs[v].exp_orphan);
      if (vecs[v].exp_valid != 4'h0) begin
        popOne();
        checkOutput($sformatf("vec%0d.afterPop", v), 32'(validMask()), 32'h0);
      end
    end

    // Filtered 3-beat TLP never shows up on the read side
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b1, 32'h0200);
    checkOutput("drop.b0.valid", 32'(validMask()), 32'h0);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 32'h0204);
    checkOutput("drop.b1.valid", 32'(validMask()), 32'h0);
    applyStimulus(4'h3, 1'b0, 1'b1, 1'b0, 32'h0208);
    idleIn();
    @(posedge clk); #1;
    checkOutput("drop.b2.valid", 32'(validMask()), 32'h0);
    checkCounters("drop", 32'd4, 32'd2, 32'd2);

    // Following unfiltered 3-beat TLP passes intact
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 32'h0300);
    applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 32'h0304);
    applyStimulus(4'h3, 1'b0, 1'b1, 1'b0, 32'h0308);
    idleIn();
    @(posedge clk); #1;
    checkHead("pass.b0", 4'hF, 4'h1, 4'h0, 32'h0300);
    popOne();
    checkHead("pass.b1", 4'hF, 4'h0, 4'h0, 32'h0304);
    popOne();
    checkHead("pass.b2", 4'h3, 4'h0, 4'h2, 32'h0308);
    popOne();
    checkOutput("pass.empty", 32'(validMask()), 32'h0);
    checkCounters("pass", 32'd5, 32'd2, 32'd2);

    // Fill to DEPTH, free one slot, then store a 17th beat
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(k * 16));
    end
    idleIn();
    checkOutput("full.tready", 32'(tready), 32'h0);
    @(posedge clk); #1;
    checkOutput("full.holdTready", 32'(tready), 32'h0);
    checkOutput("full.head", rx_data[0], 32'h1000);
    popOne();
    checkOutput("full.tready_back", 32'(tready), 32'h1);
    checkOutput("full.nextHead", rx_data[0], 32'h1010);
    applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 32'h1100);
    idleIn();
    for (int k = 1; k <= DEPTH; k++) begin
      checkOutput($sformatf("fill.order%0d", k), rx_data[0],
                  (k < DEPTH) ? 32'h1000 + 32'(k * 16) : 32'h1100);
      popOne();
    end
    checkOutput("fill.empty", 32'(validMask()), 32'h0);
    checkOutput("fill.cnt_tlp", 32'(cnt_tlp), 32'd22);

    // Simultaneous push and pop at occupancy 8
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 32'h2000 + 32'(k * 16));
    end
    idleIn();
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      driveBeat(4'hF, 1'b1, 1'b1, 1'b0, 32'h2000 + 32'((8 + c) * 16));
      rx_rd_en = 1'b1;
      checkOutput($sformatf("both%0d.tready", c), 32'(tready), 32'h1);
      checkOutput($sformatf("both%0d.head", c), rx_data[0], 32'h2000 + 32'(c * 16));
      @(posedge clk); #1;
    end
    rx_rd_en = 1'b0;
    idleIn();
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("bothDrain%0d.valid", j), 32'(rx_valid[0]), 32'h1);
      checkOutput($sformatf("bothDrain%0d.data", j), rx_data[0], 32'h2000 + 32'((20 + j) * 16));
      popOne();
    end
    checkOutput("both.empty", 32'(validMask()), 32'h0);
    checkOutput("both.cnt_tlp", 32'(cnt_tlp), 32'd50);

    // Reset in the middle of a TLP with 5 entries buffered
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 32'h3000);
    for (int k = 1; k < 5; k++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 1'b0, 32'h3000 + 32'(k * 16));
    end
    idleIn();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midReset.valid", 32'(validMask()), 32'h0);
    checkOutput("midReset.tready", 32'(tready), 32'h0);
    checkCounters("midReset", 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postReset.valid", 32'(validMask()), 32'h0);
    applyStimulus(4'h7, 1'b1, 1'b1, 1'b0, 32'h4000);
    idleIn();
    @(posedge clk); #1;
    checkHead("postReset", 4'h7, 4'h1, 4'h4, 32'h4000);
    checkCounters("postReset", 32'd1, 32'd0, 32'd0);
    popOne();
    checkOutput("postReset.empty", 32'(validMask()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
